// File: rtl/wb_commit_buffer.sv
// wb_commit_buffer
//   Writeback stage after the writeback-data select. Load data is aligned and
//   sign/zero-extended before being stored, and results queue in a 2-entry
//   in-order buffer that drains into the register-file write port. Queued
//   results are visible to the forwarding lookup.
//
//   Ports
//     clk, rst          clock; synchronous active-low reset
//     in_valid/in_ready upstream handshake (in_ready depends on state only)
//     in_reg_write, in_rd, in_is_load, in_funct3, in_addr_lo,
//     in_wb_data, in_mem_rdata   upstream result and load alignment info
//     flush             drop all queued results and any same-cycle input
//     rf_ready          register-file port accepts a write
//     rf_we, rf_rd, rf_wdata     head entry presented to the register file
//     fwd_rs -> fwd_hit, fwd_data  youngest queued value for fwd_rs
//     count             occupancy 0..2
module wb_commit_buffer #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_reg_write,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic              in_is_load,
    input  logic [2:0]        in_funct3,
    input  logic [1:0]        in_addr_lo,
    input  logic [XLEN-1:0]   in_wb_data,
    input  logic [XLEN-1:0]   in_mem_rdata,
    input  logic              flush,
    input  logic              rf_ready,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_rd,
    output logic [XLEN-1:0]   rf_wdata,
    output logic              fwd_hit,
    input  logic [ADDR_W-1:0] fwd_rs,
    output logic [XLEN-1:0]   fwd_data,
    output logic [1:0]        count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [XLEN-1:0]   data;
    } entry_t;

    state_t          state, state_nxt;
    entry_t [1:0]    slot;        // slot[0] = head (oldest), slot[1] = tail
    entry_t          new_ent;
    logic            accept, push, pop;
    logic            ld_head_new, ld_tail_new, ld_head_shift;

    // Load alignment: byte/half picked by address, then extended.
    function automatic logic [XLEN-1:0] align(input logic [2:0]      f3,
                                              input logic [1:0]      lo,
                                              input logic [XLEN-1:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        logic [XLEN-1:0] r;
        b = w[{lo, 3'b000} +: 8];
        h = lo[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  r = {{(XLEN-8){b[7]}}, b};
            3'b100:  r = {{(XLEN-8){1'b0}}, b};
            3'b001:  r = {{(XLEN-16){h[15]}}, h};
            3'b101:  r = {{(XLEN-16){1'b0}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

    assign in_ready = (state != FULL);
    assign count    = state;
    assign accept   = in_valid & in_ready & ~flush;
    // x0 and non-writing results are consumed but never queued.
    assign push     = accept & in_reg_write & (in_rd != '0);
    assign rf_we    = (state != EMPTY) & ~flush;
    assign pop      = rf_we & rf_ready;
    assign rf_rd    = slot[0].rd;
    assign rf_wdata = slot[0].data;

    assign new_ent.rd   = in_rd;
    assign new_ent.data = in_is_load ? align(in_funct3, in_addr_lo, in_mem_rdata)
                                     : in_wb_data;

    always_ff @(posedge clk) begin
        if (!rst) state <= EMPTY;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        ld_head_new   = 1'b0;
        ld_tail_new   = 1'b0;
        ld_head_shift = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: if (push) begin
                    state_nxt   = ONE;
                    ld_head_new = 1'b1;
                end
                ONE: begin
                    if (push && pop) begin
                        // Head drains while the new result takes its place.
                        ld_head_new = 1'b1;
                    end else if (push) begin
                        state_nxt   = FULL;
                        ld_tail_new = 1'b1;
                    end else if (pop) begin
                        state_nxt = EMPTY;
                    end
                end
                FULL: if (pop) begin
                    state_nxt     = ONE;
                    ld_head_shift = 1'b1;
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            slot <= '0;
        end else begin
            if (ld_head_new)   slot[0] <= new_ent;
            if (ld_head_shift) slot[0] <= slot[1];
            if (ld_tail_new)   slot[1] <= new_ent;
        end
    end

    // Youngest match wins: tail is only valid when FULL.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        if (fwd_rs != '0) begin
            if (state == FULL && slot[1].rd == fwd_rs) begin
                fwd_hit  = 1'b1;
                fwd_data = slot[1].data;
            end else if (state != EMPTY && slot[0].rd == fwd_rs) begin
                fwd_hit  = 1'b1;
                fwd_data = slot[0].data;
            end
        end
    end

endmodule

// File: tb/tb_wb_commit_buffer.sv
module tb_wb_commit_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_reg_write, in_is_load;
    logic [4:0]  in_rd;
    logic [2:0]  in_funct3;
    logic [1:0]  in_addr_lo;
    logic [31:0] in_wb_data, in_mem_rdata;
    logic        flush, rf_ready, rf_we, fwd_hit;
    logic [4:0]  rf_rd, fwd_rs;
    logic [31:0] rf_wdata, fwd_data;
    logic [1:0]  count;

    int vectors = 0;
    int errs    = 0;
    bit chk_en  = 1'b0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ment_t;
    ment_t q[$];

    wb_commit_buffer #(.XLEN(32), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_reg_write(in_reg_write), .in_rd(in_rd),
        .in_is_load(in_is_load), .in_funct3(in_funct3),
        .in_addr_lo(in_addr_lo), .in_wb_data(in_wb_data),
        .in_mem_rdata(in_mem_rdata), .flush(flush),
        .rf_ready(rf_ready), .rf_we(rf_we), .rf_rd(rf_rd),
        .rf_wdata(rf_wdata), .fwd_hit(fwd_hit), .fwd_rs(fwd_rs),
        .fwd_data(fwd_data), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Load alignment from the ISA rules, via shifts and masks.
    function automatic logic [31:0] m_align(input logic [2:0] f3, input logic [1:0] a,
                                            input logic [31:0] w);
        int unsigned v;
        int unsigned ai;
        ai = a;
        case (f3)
            3'd0, 3'd4: begin
                v = (w >> (ai * 8)) & 32'hFF;
                if (f3 == 3'd0 && v >= 128) v = v | 32'hFFFF_FF00;
            end
            3'd1, 3'd5: begin
                v = (w >> ((ai / 2) * 16)) & 32'hFFFF;
                if (f3 == 3'd1 && v >= 32768) v = v | 32'hFFFF_0000;
            end
            default: v = w;
        endcase
        return v;
    endfunction

    // Model state update: FIFO queue semantics.
    always @(posedge clk) begin
        if (!rst || flush) begin
            q.delete();
        end else begin
            int sz;
            ment_t e;
            sz = q.size();
            if (sz != 0 && rf_ready) void'(q.pop_front());
            if (in_valid && sz != 2 && in_reg_write && in_rd != 0) begin
                e.rd   = in_rd;
                e.data = in_is_load ? m_align(in_funct3, in_addr_lo, in_mem_rdata) : in_wb_data;
                q.push_back(e);
            end
        end
    end

    // Compare process: every cycle once out of initial reset.
    always @(negedge clk) begin
        if (chk_en) begin
            logic        ehit;
            logic [31:0] edata;
            ehit  = 1'b0;
            edata = 32'h0;
            chk("count", {30'd0, count}, q.size());
            chk("in_ready", {31'd0, in_ready}, {31'd0, q.size() != 2});
            chk("rf_we", {31'd0, rf_we}, {31'd0, (q.size() != 0) && !flush});
            if (q.size() != 0 && !flush) begin
                chk("rf_rd", {27'd0, rf_rd}, {27'd0, q[0].rd});
                chk("rf_wdata", rf_wdata, q[0].data);
            end
            if (fwd_rs != 0) begin
                for (int i = q.size() - 1; i >= 0; i--) begin
                    if (!ehit && q[i].rd == fwd_rs) begin
                        ehit  = 1'b1;
                        edata = q[i].data;
                    end
                end
            end
            chk("fwd_hit", {31'd0, fwd_hit}, {31'd0, ehit});
            chk("fwd_data", fwd_data, edata);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rd, input logic ld,
                         input logic [2:0] f3, input logic [1:0] a,
                         input logic [31:0] wb, input logic [31:0] md);
        in_valid     = v;
        in_reg_write = 1'b1;
        in_rd        = rd;
        in_is_load   = ld;
        in_funct3    = f3;
        in_addr_lo   = a;
        in_wb_data   = wb;
        in_mem_rdata = md;
    endtask

    logic [2:0]  lf3 [6] = '{3'd4, 3'd0, 3'd4, 3'd1, 3'd2, 3'd3};
    logic [1:0]  lad [6] = '{2'd1, 2'd2, 2'd2, 2'd1, 2'd3, 2'd0};
    logic [31:0] lmd [6] = '{32'h80FF_1234, 32'h80FF_1234, 32'h80FF_1234,
                             32'h0000_8001, 32'hCAFE_F00D, 32'h1357_9BDF};

    initial begin
        rst = 1'b0; flush = 1'b0; rf_ready = 1'b1; fwd_rs = 5'd0;
        drive(1'b0, 5'd0, 1'b0, 3'd0, 2'd0, 32'h0, 32'h0);
        step(); step();
        rst = 1'b1;
        chk_en = 1'b1;
        chk("rst_count", {30'd0, count}, 32'd0);
        chk("rst_rf_we", {31'd0, rf_we}, 32'd0);

        // 1: LB byte 3 of 0x80FF_1234 -> 0x80 sign-extended
        drive(1'b1, 5'd5, 1'b1, 3'b000, 2'd3, 32'h0, 32'h80FF_1234);
        fwd_rs = 5'd5;
        step();
        in_valid = 1'b0;
        chk("t1_rf_we", {31'd0, rf_we}, 32'd1);
        chk("t1_rf_rd", {27'd0, rf_rd}, 32'd5);
        chk("t1_wdata", rf_wdata, 32'hFFFF_FF80);
        step();

        // 2: LHU then LH of upper half 0xBEEF
        drive(1'b1, 5'd7, 1'b1, 3'b101, 2'd2, 32'h0, 32'hBEEF_0000);
        fwd_rs = 5'd7;
        step();
        chk("t2_lhu", rf_wdata, 32'h0000_BEEF);
        in_funct3 = 3'b001;
        step();
        in_valid = 1'b0;
        chk("t2_lh", rf_wdata, 32'hFFFF_BEEF);
        chk("t2_count", {30'd0, count}, 32'd1);
        step();

        // 3: write to x0 is consumed and dropped
        drive(1'b1, 5'd0, 1'b0, 3'd0, 2'd0, 32'h1234_5000, 32'h0);
        fwd_rs = 5'd0;
        step();
        in_valid = 1'b0;
        chk("t3_count", {30'd0, count}, 32'd0);
        chk("t3_rf_we", {31'd0, rf_we}, 32'd0);
        step();

        // 4: backpressure, FIFO order
        rf_ready = 1'b0;
        fwd_rs = 5'd2;
        drive(1'b1, 5'd1, 1'b0, 3'd0, 2'd0, 32'd1, 32'h0);
        step();
        in_rd = 5'd2; in_wb_data = 32'd2;
        step();
        chk("t4_in_ready", {31'd0, in_ready}, 32'd0);
        in_rd = 5'd3; in_wb_data = 32'd3;
        step();
        chk("t4_hold_rd", {27'd0, rf_rd}, 32'd1);
        rf_ready = 1'b1;
        step();
        chk("t4_second", {27'd0, rf_rd}, 32'd2);
        step();
        in_valid = 1'b0;
        chk("t4_third_rd", {27'd0, rf_rd}, 32'd3);
        chk("t4_third_d", rf_wdata, 32'd3);
        step();

        // 5: forward youngest of two x4 entries, then flush
        rf_ready = 1'b0;
        drive(1'b1, 5'd4, 1'b0, 3'd0, 2'd0, 32'h0000_000A, 32'h0);
        step();
        in_wb_data = 32'h0000_000B;
        step();
        in_valid = 1'b0;
        fwd_rs = 5'd4;
        #1;
        chk("t5_fwd_hit", {31'd0, fwd_hit}, 32'd1);
        chk("t5_fwd_data", fwd_data, 32'h0000_000B);
        flush = 1'b1;
        drive(1'b1, 5'd6, 1'b0, 3'd0, 2'd0, 32'h66, 32'h0);
        #1;
        chk("t5_flush_we", {31'd0, rf_we}, 32'd0);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("t5_count", {30'd0, count}, 32'd0);
        chk("t5_rf_we", {31'd0, rf_we}, 32'd0);
        step();

        // 6: reset while full, then a normal push
        drive(1'b1, 5'd8, 1'b0, 3'd0, 2'd0, 32'h88, 32'h0);
        step();
        in_rd = 5'd10; in_wb_data = 32'hAA;
        step();
        in_valid = 1'b0;
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("t6_count", {30'd0, count}, 32'd0);
        chk("t6_rf_we", {31'd0, rf_we}, 32'd0);
        chk("t6_rf_rd", {27'd0, rf_rd}, 32'd0);
        chk("t6_wdata", rf_wdata, 32'd0);
        rf_ready = 1'b1;
        drive(1'b1, 5'd9, 1'b0, 3'd0, 2'd0, 32'h55, 32'h0);
        fwd_rs = 5'd9;
        step();
        in_valid = 1'b0;
        chk("t6_post_rd", {27'd0, rf_rd}, 32'd9);
        chk("t6_post_d", rf_wdata, 32'h55);
        step();

        // Load alignment sweep, streamed back-to-back with mixed readiness
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 5'(11 + i), 1'b1, lf3[i], lad[i], 32'hDEAD_BEEF, lmd[i]);
            fwd_rs = 5'(11 + i);
            rf_ready = (i % 2 == 0);
            step();
        end
        in_valid = 1'b0;
        rf_ready = 1'b1;
        step(); step(); step();
        chk("end_count", {30'd0, count}, 32'd0);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
